// File: rtl/hilo_unit_if.sv
// Handshake and data bundle between control/multiplier and the HI/LO sequencer.
// master drives the request side; slave is the hilo_unit itself.
interface hilo_unit_if;
  logic        MulStart;
  logic [64:0] Produto;
  logic        EndMulFlag;
  logic        HiWrite;
  logic        LoWrite;
  logic [31:0] WriteData;
  logic        ReadSel;
  logic [31:0] ReadData;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        MulBusy;
  logic        MulDone;
  logic        MulTimeout;

  modport master (
    output MulStart, Produto, EndMulFlag, HiWrite, LoWrite, WriteData, ReadSel,
    input  ReadData, Hi, Lo, MulBusy, MulDone, MulTimeout
  );

  modport slave (
    input  MulStart, Produto, EndMulFlag, HiWrite, LoWrite, WriteData, ReadSel,
    output ReadData, Hi, Lo, MulBusy, MulDone, MulTimeout
  );
endinterface

// File: rtl/hilo_unit.sv
// MULT result sequencer: waits out the multiplier's stale completion flag, captures
// the 64-bit product into HI/LO, and serves MTHI/MTLO/MFHI/MFLO.
module hilo_unit #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic       Clk,
  input  logic       Reset_n,
  hilo_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, WAIT} state_t;

  localparam logic [6:0] TMO_CNT = 7'(TIMEOUT);
  localparam logic [6:0] CNT_MAX = 7'd127;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d, cnt_inc;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        tmo_q, tmo_d;
  logic        prod_unused;

  assign prod_unused = bus.Produto[64];
  assign cnt_inc     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 7'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (bus.HiWrite) hi_d = bus.WriteData;
        if (bus.LoWrite) lo_d = bus.WriteData;
        if (bus.MulStart) begin
          state_d = ARM;
          cnt_d   = 7'd0;
        end
      end
      ARM, WAIT: begin
        cnt_d = cnt_inc;
        // A capture landing on the same edge as the timeout wins.
        if (state_q == WAIT && bus.EndMulFlag) begin
          hi_d    = bus.Produto[63:32];
          lo_d    = bus.Produto[31:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_inc == TMO_CNT) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else if (state_q == ARM && !bus.EndMulFlag) begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 7'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.Hi         = hi_q;
  assign bus.Lo         = lo_q;
  assign bus.ReadData   = bus.ReadSel ? hi_q : lo_q;
  assign bus.MulBusy    = (state_q != IDLE);
  assign bus.MulDone    = done_q;
  assign bus.MulTimeout = tmo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Randomized bench for hilo_unit against a cycle-level behavioural model of the
// MULT/MTHI/MTLO rules, including a reset asserted in the middle of a multiply.
module tb_hilo_unit;
  localparam int TIMEOUT = 40;
  localparam int NCYC    = 3000;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;

  hilo_unit_if bus();

  hilo_unit #(.TIMEOUT(TIMEOUT)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus.slave)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_busy, m_seen_low, m_done, m_tmo;
  int          m_elapsed;
  logic [31:0] m_hi, m_lo;

  // Multiplier-flag generator state
  int  since = -1;
  int  fall_at, rise_at;
  bit  stale;
  bit  did_rst = 0;
  int  n_done = 0, n_tmo = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("Hi",         {32'd0, bus.Hi},        {32'd0, m_hi});
    chk("Lo",         {32'd0, bus.Lo},        {32'd0, m_lo});
    chk("ReadData",   {32'd0, bus.ReadData},  {32'd0, bus.ReadSel ? m_hi : m_lo});
    chk("MulBusy",    {63'd0, bus.MulBusy},   {63'd0, m_busy});
    chk("MulDone",    {63'd0, bus.MulDone},   {63'd0, m_done});
    chk("MulTimeout", {63'd0, bus.MulTimeout},{63'd0, m_tmo});
  endtask

  task automatic model_reset();
    m_busy = 0; m_seen_low = 0; m_done = 0; m_tmo = 0;
    m_elapsed = 0; m_hi = '0; m_lo = '0;
  endtask

  // One clock edge of the architectural behaviour, from the inputs now on the bus.
  task automatic model_edge();
    m_done = 0;
    if (!m_busy) begin
      if (bus.HiWrite) m_hi = bus.WriteData;
      if (bus.LoWrite) m_lo = bus.WriteData;
      if (bus.MulStart) begin
        m_busy = 1; m_elapsed = 0; m_seen_low = 0;
      end
    end else begin
      m_elapsed++;
      if (m_seen_low && bus.EndMulFlag) begin
        m_hi = bus.Produto[63:32];
        m_lo = bus.Produto[31:0];
        m_done = 1; m_busy = 0; n_done++;
      end else if (m_elapsed >= TIMEOUT) begin
        m_tmo = 1; m_busy = 0; n_tmo++;
      end else if (!bus.EndMulFlag) begin
        m_seen_low = 1;
      end
    end
  endtask

  initial begin
    bus.MulStart = 0; bus.Produto = '0; bus.EndMulFlag = 0;
    bus.HiWrite = 0; bus.LoWrite = 0; bus.WriteData = '0; bus.ReadSel = 0;
    model_reset();
    #2;
    check_all();
    repeat (2) @(negedge Clk);
    Reset_n = 1;

    for (int i = 0; i < NCYC; i++) begin
      @(negedge Clk);
      if (since >= 0) begin
        since++;
        bus.EndMulFlag = (since < fall_at) ? stale : (since < rise_at ? 1'b0 : 1'b1);
      end
      bus.MulStart  = m_busy ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
      bus.HiWrite   = ($urandom_range(0, 3) == 0);
      bus.LoWrite   = ($urandom_range(0, 3) == 0);
      bus.WriteData = $urandom;
      bus.ReadSel   = $urandom_range(0, 1) == 1;
      bus.Produto   = {1'($urandom), $urandom, $urandom};
      if (bus.MulStart && !m_busy) begin
        since   = 0;
        stale   = bus.EndMulFlag;
        fall_at = $urandom_range(1, 3);
        rise_at = ($urandom_range(0, 5) == 0) ? 1000000 : fall_at + $urandom_range(25, 45);
      end
      model_edge();
      @(posedge Clk);
      #1;
      check_all();

      if (!did_rst && i > NCYC / 2 && m_busy && m_seen_low) begin
        did_rst = 1;
        #2;
        Reset_n = 0;
        #1;
        model_reset();
        check_all();
        since = -1;
        for (int k = 0; k < 3; k++) begin
          @(negedge Clk);
          bus.EndMulFlag = 1;
          bus.MulStart = 0; bus.HiWrite = 0; bus.LoWrite = 0;
          @(posedge Clk);
          #1;
          check_all();
        end
        @(negedge Clk);
        Reset_n = 1;
      end
    end

    chk("reset_exercised", {63'd0, did_rst}, 64'd1);
    chk("captures_seen",   {63'd0, (n_done > 5)}, 64'd1);
    chk("timeouts_seen",   {63'd0, (n_tmo > 0)},  64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #((NCYC + 200) * 10 * 2);
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
